// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//   Multi-cycle instruction fetch unit. It owns the program counter (pc) and
//   the instruction register (ir), and fetches one word at a time from
//   instruction memory over a req/ack handshake. The latched instruction is
//   presented to the control decoder and the datapath. When the datapath
//   signals completion, the decoder's NPCOp selects the next pc.
//
//   Sequence: IDLE -> FETCH -> EXEC -> FETCH -> ...
//   There is no prefetch. A new fetch starts the cycle after exec_done.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous reset, active low
//   im_req       fetch request, high throughout FETCH
//   im_addr      fetch address, always equal to pc
//   im_ack       memory returns im_rdata this cycle
//   im_rdata     instruction word, captured on im_req && im_ack
//   instr_valid  ir holds an instruction awaiting execution (EXEC)
//   exec_done    datapath finished the instruction; advance pc
//   NPCOp        next-pc select: 00 pc+4, 01 branch, 10 jump, 11 jr
//   ra_in        register target used by jr
//   ir           latched instruction word
//   OP, Funct    ir[31:26] and ir[5:0]
//   pc           address of the instruction in ir
//   pc_plus4     pc + 4, the link value for jal
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] ra_in,
  output logic [31:0] ir,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_off_s;
  logic [31:0] npc_s;

  assign pc_plus4_s = pc_q + 32'd4;
  // The branch offset is a sign-extended word offset, scaled to bytes.
  assign br_off_s   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // Next-pc selection from the decoder's NPCOp.
  always_comb begin
    npc_s = pc_plus4_s;
    case (NPCOp)
      2'b00:   npc_s = pc_plus4_s;
      2'b01:   npc_s = pc_plus4_s + br_off_s;
      2'b10:   npc_s = {pc_plus4_s[31:28], ir_q[25:0], 2'b00};
      2'b11:   npc_s = ra_in & 32'hFFFF_FFFC;
      default: npc_s = pc_plus4_s;
    endcase
  end

  // FSM next-state logic and pc/ir update decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (im_ack) begin
          ir_d    = im_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // Clear the low bits so that the next pc stays word aligned.
          pc_d    = npc_s & 32'hFFFF_FFFC;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pc and ir registers. The reset abandons any fetch or exec at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // im_req and instr_valid are Moore outputs, decoded from the state register only.
  assign im_req      = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign ir          = ir_q;
  assign OP          = ir_q[31:26];
  assign Funct       = ir_q[5:0];

endmodule
